credit_rr_arbiter: RTL and testbench

//   Shares a pool of MAX_CREDITS downstream credits between NUM_REQ requesters.

---
 rtl/credit_rr_arbiter.sv | 102 ++++++++++
 tb/tb_credit_rr_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/credit_rr_arbiter.sv
// Round-robin arbiter that hands out grants only while downstream credits remain.
// The credit count is tracked here: each grant consumes one credit and each return gives one back.
module credit_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_CREDITS = 16,
  parameter int CNT_W       = 8,
  parameter int IDX_W       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic               credit_return_in,
  output logic [NUM_REQ-1:0] grant_out,
  output logic               grant_valid_out,
  output logic [IDX_W-1:0]   grant_idx_out,
  output logic [CNT_W-1:0]   credits_avail_out,
  output logic               overflow_err_out
);

  localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MAX_CREDITS);
  localparam logic [IDX_W:0]   NumReqW = (IDX_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   gntIdx_q, gntIdx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   winIdx;
  logic               winFound;
  logic [IDX_W:0]     cand;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               grantNow;
  logic               atMax;

  // A requester granted this cycle sits out the next decision.
  assign elig = req_in & ~grant_q;

  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(i + 1);
      if (cand >= NumReqW) begin
        cand = cand - NumReqW;
      end
      if (!winFound && elig[cand[IDX_W-1:0]]) begin
        winFound = 1'b1;
        winIdx   = cand[IDX_W-1:0];
      end
    end
  end

  // Gating looks only at the registered count, so a same-cycle return cannot unblock an empty pool.
  assign grantNow = winFound && (count_q != '0);
  assign atMax    = (count_q == MaxCnt);

  always_comb begin
    grant_d    = '0;
    gntIdx_d   = '0;
    last_d     = last_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (grantNow) begin
      grant_d  = NUM_REQ'(1) << winIdx;
      gntIdx_d = winIdx;
      last_d   = winIdx;
    end
    if (grantNow && !credit_return_in) begin
      count_d = count_q - CNT_W'(1);
    end else if (!grantNow && credit_return_in) begin
      if (atMax) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= '0;
      gntIdx_q   <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      count_q    <= MaxCnt;
      overflow_q <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      gntIdx_q   <= gntIdx_d;
      last_q     <= last_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign grant_out         = grant_q;
  assign grant_valid_out   = |grant_q;
  assign grant_idx_out     = gntIdx_q;
  assign credits_avail_out = count_q;
  assign overflow_err_out  = overflow_q;

endmodule

// File: tb/tb_credit_rr_arbiter.sv
// Bench for credit_rr_arbiter: a behavioural model checked every cycle plus directed literal checks.
module tb_credit_rr_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int MAX_CREDITS = 16;
  localparam int CNT_W       = 8;
  localparam int IDX_W       = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] req_in;
  logic               credit_return_in;
  logic [NUM_REQ-1:0] grant_out;
  logic               grant_valid_out;
  logic [IDX_W-1:0]   grant_idx_out;
  logic [CNT_W-1:0]   credits_avail_out;
  logic               overflow_err_out;

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;

  int mGrant = -1;
  int mCount = MAX_CREDITS;
  int mLast  = NUM_REQ - 1;
  bit mOvf   = 1'b0;

  credit_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_CREDITS(MAX_CREDITS), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_in(req_in),
    .credit_return_in(credit_return_in),
    .grant_out(grant_out),
    .grant_valid_out(grant_valid_out),
    .grant_idx_out(grant_idx_out),
    .credits_avail_out(credits_avail_out),
    .overflow_err_out(overflow_err_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Model: the previous winner is skipped, the scan starts after the last winner, credits are plain integers.
  always @(posedge clk) begin : model
    int win;
    int idx;
    bit g;
    if (rst) begin
      mGrant <= -1;
      mCount <= MAX_CREDITS;
      mLast  <= NUM_REQ - 1;
      mOvf   <= 1'b0;
    end else begin
      win = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (mLast + k) % NUM_REQ;
        if (win < 0 && req_in[idx] && idx != mGrant) win = idx;
      end
      g = (mCount > 0) && (win >= 0);
      mGrant <= g ? win : -1;
      if (g) mLast <= win;
      if (g && !credit_return_in) mCount <= mCount - 1;
      else if (!g && credit_return_in) begin
        if (mCount == MAX_CREDITS) mOvf <= 1'b1;
        else mCount <= mCount + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model grant_out", 32'(grant_out), (mGrant >= 0) ? (32'd1 << mGrant) : 32'd0);
      checkOutput("model grant_valid", 32'(grant_valid_out), (mGrant >= 0) ? 32'd1 : 32'd0);
      checkOutput("model grant_idx", 32'(grant_idx_out), (mGrant >= 0) ? 32'(mGrant) : 32'd0);
      checkOutput("model credits", 32'(credits_avail_out), 32'(mCount));
      checkOutput("model overflow", 32'(overflow_err_out), 32'(mOvf));
    end
  end

  // Drives inputs just after an edge, then advances n edges and returns 2 time units past the last one.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic ret, input int n);
    req_in = r;
    credit_return_in = ret;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic checkState(input string name, input logic [31:0] gnt, input logic [31:0] cnt, input logic [31:0] ovf);
    checkOutput({name, " grant"}, 32'(grant_out), gnt);
    checkOutput({name, " credits"}, 32'(credits_avail_out), cnt);
    checkOutput({name, " overflow"}, 32'(overflow_err_out), ovf);
  endtask

  initial begin
    rst = 1'b1;
    req_in = '0;
    credit_return_in = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkState("reset", 32'h0, 32'd16, 32'd0);
    checkOutput("reset idx", 32'(grant_idx_out), 32'd0);
    checkEn = 1'b1;
    rst = 1'b0;

    // All four requesting: strict 0,1,2,3 rotation until the pool drains.
    applyStimulus(4'b1111, 1'b0, 1);
    checkState("rr first", 32'h1, 32'd15, 32'd0);
    applyStimulus(4'b1111, 1'b0, 1);
    checkState("rr second", 32'h2, 32'd14, 32'd0);
    checkOutput("rr second idx", 32'(grant_idx_out), 32'd1);
    applyStimulus(4'b1111, 1'b0, 1);
    checkOutput("rr third idx", 32'(grant_idx_out), 32'd2);
    applyStimulus(4'b1111, 1'b0, 13);
    checkState("rr sixteenth", 32'h8, 32'd0, 32'd0);
    applyStimulus(4'b1111, 1'b0, 1);
    checkState("rr drained", 32'h0, 32'd0, 32'd0);

    // Empty pool: a return enables a grant only on the following edge.
    applyStimulus(4'b0001, 1'b1, 1);
    checkState("return at zero", 32'h0, 32'd1, 32'd0);
    applyStimulus(4'b0001, 1'b0, 1);
    checkState("grant after return", 32'h1, 32'd0, 32'd0);

    rst = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1);
    rst = 1'b0;

    // One held requester is granted every other cycle.
    applyStimulus(4'b0100, 1'b0, 1);
    checkState("single first", 32'h4, 32'd15, 32'd0);
    checkOutput("single idx", 32'(grant_idx_out), 32'd2);
    applyStimulus(4'b0100, 1'b0, 1);
    checkState("single gap", 32'h0, 32'd15, 32'd0);
    applyStimulus(4'b0100, 1'b0, 1);
    checkState("single second", 32'h4, 32'd14, 32'd0);

    // Nine grants bring the count to 5; the last goes to requester 3.
    applyStimulus(4'b1111, 1'b0, 9);
    checkState("drain to five", 32'h8, 32'd5, 32'd0);
    applyStimulus(4'b0001, 1'b1, 1);
    checkState("grant plus return", 32'h1, 32'd5, 32'd0);
    applyStimulus(4'b0000, 1'b0, 1);
    checkState("idle at five", 32'h0, 32'd5, 32'd0);

    // Refill to the top, then a grant+return at the top must not flag overflow.
    applyStimulus(4'b0000, 1'b1, 11);
    checkState("refilled", 32'h0, 32'd16, 32'd0);
    applyStimulus(4'b0001, 1'b1, 1);
    checkState("full grant plus return", 32'h1, 32'd16, 32'd0);
    applyStimulus(4'b0000, 1'b1, 1);
    checkState("overflow", 32'h0, 32'd16, 32'd1);
    applyStimulus(4'b0000, 1'b0, 3);
    checkState("overflow sticky", 32'h0, 32'd16, 32'd1);

    // Bring the count to 3, then reset while requests are pending.
    applyStimulus(4'b1111, 1'b0, 13);
    checkOutput("pre-reset credits", 32'(credits_avail_out), 32'd3);
    rst = 1'b1;
    applyStimulus(4'b1111, 1'b0, 1);
    checkState("mid reset", 32'h0, 32'd16, 32'd0);
    rst = 1'b0;
    applyStimulus(4'b0110, 1'b0, 1);
    checkState("post reset", 32'h2, 32'd15, 32'd0);
    checkOutput("post reset idx", 32'(grant_idx_out), 32'd1);

    applyStimulus(4'b0000, 1'b0, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
